i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/i2s_transmitter.sv | 116 +++++++++++
 tb/tb_i2s_transmitter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S transmitter: serialises one stereo sample pair per sample strobe as a
// 2*DATA_WIDTH+1 slot frame (left then right, MSB first, one-bit I2S delay).
module i2s_transmitter #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] right_in,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  busy,
    output logic                  overrun
);

    localparam int FRAME_W = 2 * DATA_WIDTH;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W  = $clog2(FRAME_W + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_W);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(DATA_WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state, state_d;
    logic [DIV_W-1:0]    div_cnt, div_cnt_d;
    logic [SLOT_W-1:0]   slot_cnt, slot_cnt_d, slot_inc;
    logic [FRAME_W-1:0]  shreg, shreg_d;
    logic                bclk_d, lrclk_d, sdata_d, overrun_d;

    assign busy = (state == SHIFT);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state;
        div_cnt_d  = div_cnt;
        slot_cnt_d = slot_cnt;
        shreg_d    = shreg;
        bclk_d     = bclk;
        lrclk_d    = lrclk;
        sdata_d    = sdata;
        slot_inc   = slot_cnt + 1'b1;
        overrun_d  = sample_valid && (state == SHIFT);

        case (state)
            IDLE: begin
                if (sample_valid) begin
                    state_d    = SHIFT;
                    shreg_d    = {left_in, right_in};
                    div_cnt_d  = '0;
                    slot_cnt_d = '0;
                    bclk_d     = 1'b0;
                    lrclk_d    = 1'b0;
                    sdata_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt_d = div_cnt + 1'b1;
                end else begin
                    div_cnt_d = '0;
                    if (!bclk) begin
                        bclk_d = 1'b1;
                    end else if (slot_cnt == SLOT_LAST) begin
                        // End of the trailing slot: drop everything back to idle.
                        state_d    = IDLE;
                        bclk_d     = 1'b0;
                        lrclk_d    = 1'b0;
                        sdata_d    = 1'b0;
                        slot_cnt_d = '0;
                        shreg_d    = '0;
                    end else begin
                        // Falling bclk opens the next slot; lrclk/sdata move only here.
                        bclk_d     = 1'b0;
                        slot_cnt_d = slot_inc;
                        lrclk_d    = (slot_inc >= SLOT_RIGHT) && (slot_inc != SLOT_LAST);
                        sdata_d    = shreg[FRAME_W-1];
                        shreg_d    = {shreg[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            slot_cnt <= '0;
            shreg    <= '0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_d;
            div_cnt  <= div_cnt_d;
            slot_cnt <= slot_cnt_d;
            shreg    <= shreg_d;
            bclk     <= bclk_d;
            lrclk    <= lrclk_d;
            sdata    <= sdata_d;
            overrun  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: two configurations checked cycle by
// cycle against a slot-arithmetic reference model, plus directed frame checks.
module tb_i2s_transmitter;

    localparam int W  = 16;
    localparam int C  = 2;
    localparam int W2 = 4;
    localparam int C2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        sv_a = 1'b0;
    logic [15:0] l_a = '0, r_a = '0;
    logic        bclk_a, lrclk_a, sdata_a, busy_a, ovr_a;
    logic        sv_b = 1'b0;
    logic [3:0]  l_b = '0, r_b = '0;
    logic        bclk_b, lrclk_b, sdata_b, busy_b, ovr_b;

    logic [4:0] obs_a, obs_b;
    assign obs_a = {busy_a, bclk_a, lrclk_a, sdata_a, ovr_a};
    assign obs_b = {busy_b, bclk_b, lrclk_b, sdata_b, ovr_b};

    i2s_transmitter #(.DATA_WIDTH(W), .CLK_DIV(C)) dut_a (
        .clk(clk), .rst(rst), .sample_valid(sv_a), .left_in(l_a), .right_in(r_a),
        .bclk(bclk_a), .lrclk(lrclk_a), .sdata(sdata_a), .busy(busy_a), .overrun(ovr_a)
    );

    i2s_transmitter #(.DATA_WIDTH(W2), .CLK_DIV(C2)) dut_b (
        .clk(clk), .rst(rst), .sample_valid(sv_b), .left_in(l_b), .right_in(r_b),
        .bclk(bclk_b), .lrclk(lrclk_b), .sdata(sdata_b), .busy(busy_b), .overrun(ovr_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: cycle at which slot 0 of the current frame begins.
    int          a_start = -100000, b_start = -100000;
    logic [63:0] a_word = '0, b_word = '0;
    logic        a_ovr = 1'b0, b_ovr = 1'b0;
    logic [4:0]  exp_a = '0, exp_b = '0;

    function automatic logic in_frame(input int n, input int w, input int c);
        return (n >= 0) && (n < (2 * w + 1) * 2 * c);
    endfunction

    // {busy, bclk, lrclk, sdata} at cycle offset n from frame start.
    function automatic logic [3:0] frame_out(input int n, input int w, input int c,
                                             input logic [63:0] word);
        logic [3:0] o;
        int k;
        o = 4'b0;
        if (in_frame(n, w, c)) begin
            k    = n / (2 * c);
            o[3] = 1'b1;
            o[2] = (n % (2 * c)) >= c;
            o[1] = (k >= w) && (k < 2 * w);
            o[0] = (k == 0) ? 1'b0 : word[2 * w - k];
        end
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            a_start = -100000; b_start = -100000;
            a_ovr = 1'b0; b_ovr = 1'b0;
        end else begin
            a_ovr = sv_a && in_frame(cyc - a_start, W, C);
            if (sv_a && !in_frame(cyc - a_start, W, C)) begin
                a_start = cyc + 1;
                a_word  = {32'b0, l_a, r_a};
            end
            b_ovr = sv_b && in_frame(cyc - b_start, W2, C2);
            if (sv_b && !in_frame(cyc - b_start, W2, C2)) begin
                b_start = cyc + 1;
                b_word  = {56'b0, l_b, r_b};
            end
        end
        cyc++;
        #1;
        exp_a = {frame_out(cyc - a_start, W, C, a_word), a_ovr};
        exp_b = {frame_out(cyc - b_start, W2, C2, b_word), b_ovr};
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        sv_a = 1'b1; l_a = 16'hFFFF; r_a = 16'hFFFF;
        sv_b = 1'b1; l_b = 4'hF;     r_b = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_a !== 5'b0) begin
                errors++;
                $display("FAIL reset_a cycle %0d: got %b expected 00000", i, obs_a);
            end
            checks++;
            if (obs_b !== 5'b0) begin
                errors++;
                $display("FAIL reset_b cycle %0d: got %b expected 00000", i, obs_b);
            end
        end
        sv_a = 1'b0; sv_b = 1'b0;
        rst  = 1'b1;
    endtask

    task automatic test_basic();
        logic [32:0] sd = '0, lr = '0;
        logic prev = 1'b0;
        int rises = 0, busy_cnt = 0, ovr_cnt = 0, ovr_at = -1;
        sv_a = 1'b1; l_a = 16'hA5F0; r_a = 16'h0F0F;
        for (int i = 1; i <= 133; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL basic t+%0d: got %b expected %b", i, obs_a, exp_a);
            end
            if (bclk_a && !prev) begin
                rises++;
                sd = {sd[31:0], sdata_a};
                lr = {lr[31:0], lrclk_a};
            end
            prev = bclk_a;
            if (busy_a) busy_cnt++;
            if (ovr_a) begin ovr_cnt++; ovr_at = i; end
            if (i <= 132) begin
                sv_a = (i == 50);
                l_a  = (i == 50) ? 16'h1234 : 16'($urandom);
                r_a  = 16'($urandom);
            end
        end
        checks++;
        if (sd !== {1'b0, 32'hA5F00F0F}) begin
            errors++; $display("FAIL basic_sdata: got %h expected %h", sd, {1'b0, 32'hA5F00F0F});
        end
        checks++;
        if (lr !== 33'h1FFFE) begin
            errors++; $display("FAIL basic_lrclk: got %h expected %h", lr, 33'h1FFFE);
        end
        checks++;
        if (rises != 33) begin
            errors++; $display("FAIL basic_rises: got %0d expected 33", rises);
        end
        checks++;
        if (busy_cnt != 132) begin
            errors++; $display("FAIL basic_busy_len: got %0d expected 132", busy_cnt);
        end
        checks++;
        if (ovr_cnt != 1 || ovr_at != 51) begin
            errors++; $display("FAIL basic_overrun: got %0d pulses at t+%0d expected 1 at t+51", ovr_cnt, ovr_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] sd = '0;
        logic prev = 1'b0;
        int rises = 0, ovr_cnt = 0;
        sv_a = 1'b1; l_a = 16'h8000; r_a = 16'h7FFF;
        for (int i = 1; i <= 133; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL b2b t+%0d: got %b expected %b", i, obs_a, exp_a);
            end
            if (bclk_a && !prev) begin rises++; sd = {sd[31:0], sdata_a}; end
            prev = bclk_a;
            if (ovr_a) ovr_cnt++;
            sv_a = 1'b0; l_a = 16'($urandom); r_a = 16'($urandom);
        end
        checks++;
        if (sd !== {1'b0, 32'h80007FFF} || rises != 33) begin
            errors++; $display("FAIL b2b_sdata: got %h (%0d edges) expected %h (33 edges)", sd, rises, {1'b0, 32'h80007FFF});
        end
        checks++;
        if (ovr_cnt != 0) begin
            errors++; $display("FAIL b2b_overrun: got %0d pulses expected 0", ovr_cnt);
        end
    endtask

    task automatic test_last_busy();
        logic [32:0] sd = '0;
        logic prev = 1'b0;
        logic [31:0] word;
        int ovr_at = -1;
        word = $urandom;
        sv_a = 1'b1; l_a = word[31:16]; r_a = word[15:0];
        for (int i = 1; i <= 134; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL last_busy t+%0d: got %b expected %b", i, obs_a, exp_a);
            end
            if (bclk_a && !prev) sd = {sd[31:0], sdata_a};
            prev = bclk_a;
            if (ovr_a) ovr_at = i;
            sv_a = (i == 132); l_a = ~word[31:16]; r_a = ~word[15:0];
        end
        checks++;
        if (sd !== {1'b0, word} || ovr_at != 133) begin
            errors++; $display("FAIL last_busy_frame: got %h ovr t+%0d expected %h ovr t+133", sd, ovr_at, {1'b0, word});
        end
    endtask

    task automatic test_reset_midframe();
        logic [32:0] sd = '0;
        logic prev = 1'b0;
        int rises = 0;
        sv_a = 1'b1; l_a = 16'($urandom); r_a = 16'($urandom);
        for (int i = 1; i <= 183; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL rst_mid t+%0d: got %b expected %b", i, obs_a, exp_a);
            end
            if (bclk_a && !prev) begin rises++; sd = {sd[31:0], sdata_a}; end
            prev = bclk_a;
            if (i == 40) begin
                rst = 1'b0;
                #1;
                a_start = -100000; a_ovr = 1'b0;
                checks++;
                if (obs_a !== 5'b0) begin
                    errors++; $display("FAIL rst_async: got %b expected 00000", obs_a);
                end
                prev = bclk_a;
            end
            if (i == 45) rst = 1'b1;
            if (i == 50) begin sd = '0; rises = 0; end
            sv_a = (i == 50);
            l_a  = (i == 50) ? 16'hFFFF : 16'($urandom);
            r_a  = (i == 50) ? 16'h0001 : 16'($urandom);
        end
        checks++;
        if (sd !== {1'b0, 32'hFFFF0001} || rises != 33) begin
            errors++; $display("FAIL rst_mid_frame: got %h (%0d edges) expected %h (33 edges)", sd, rises, {1'b0, 32'hFFFF0001});
        end
    endtask

    task automatic test_small();
        logic [8:0] sd = '0;
        logic prev = 1'b0;
        int rises = 0, busy_cnt = 0;
        sv_b = 1'b1; l_b = 4'h9; r_b = 4'h6;
        for (int i = 1; i <= 19; i++) begin
            tick();
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL small t+%0d: got %b expected %b", i, obs_b, exp_b);
            end
            if (bclk_b && !prev) begin rises++; sd = {sd[7:0], sdata_b}; end
            prev = bclk_b;
            if (busy_b) busy_cnt++;
            sv_b = 1'b0; l_b = 4'($urandom); r_b = 4'($urandom);
        end
        checks++;
        if (sd !== {1'b0, 8'h96} || rises != 9 || busy_cnt != 18) begin
            errors++; $display("FAIL small_frame: got %h edges %0d busy %0d expected %h edges 9 busy 18", sd, rises, busy_cnt, {1'b0, 8'h96});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            sv_a = ($urandom_range(0, 59) == 0);
            l_a  = 16'($urandom); r_a = 16'($urandom);
            sv_b = ($urandom_range(0, 11) == 0);
            l_b  = 4'($urandom);  r_b = 4'($urandom);
            tick();
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL random_a cycle %0d: got %b expected %b", i, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL random_b cycle %0d: got %b expected %b", i, obs_b, exp_b);
            end
        end
        sv_a = 1'b0; sv_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_last_busy();
        test_reset_midframe();
        test_small();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
